// File: rtl/fifo_read_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_unpacker
// Description : Read-side companion of the parameterised FIFO. Drains the
//               FIFO read port one PAR_READ-word beat at a time and
//               serialises each beat onto a DATA_WIDTH valid/ready stream,
//               word 0 (LSBs of fifo_dout) first.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : width of one word
//   PAR_READ   : words per FIFO read beat (>= 1), matches the FIFO
// Ports
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-high reset
//   clear      in  : synchronous flush (shared with the FIFO clear)
//   fifo_ren   out : read request to the FIFO (combinational)
//   fifo_dout  in  : FIFO read beat, word 0 in the LSBs
//   fifo_empty in  : FIFO empty flag
//   fifo_valid in  : FIFO read data valid, one cycle after an accepted read
//   m_data     out : output word
//   m_valid    out : output word valid
//   m_ready    in  : downstream accept
//   m_last     out : marks the last word of the current beat
//   err        out : sticky protocol error, cleared only by rst
// ============================================================================
module fifo_read_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_READ   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  output logic                           fifo_ren,
  input  logic [PAR_READ*DATA_WIDTH-1:0] fifo_dout,
  input  logic                           fifo_empty,
  input  logic                           fifo_valid,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           err
);

  localparam int BUF_W = PAR_READ * DATA_WIDTH;
  localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no beat held, no read outstanding
    ST_WAIT  = 2'd1,  // read issued, beat arrives this cycle
    ST_DRAIN = 2'd2   // beat held, presenting word idx
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BUF_W-1:0]   beat_buf;
  logic [BUF_W-1:0]   beat_buf_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               ignore;

  logic               handshake;
  logic               at_last;
  logic               err_set;
  logic [DATA_WIDTH-1:0] word_sel;

  assign at_last   = (idx == LAST_IDX);
  assign m_valid   = (state == ST_DRAIN);
  assign handshake = m_valid && m_ready;
  assign m_last    = m_valid && at_last;
  assign m_data    = m_valid ? word_sel : '0;

  // Word mux written as a compare loop so that a non-power-of-two PAR_READ
  // never indexes past the end of the beat.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (idx == IDX_W'(i)) begin
        word_sel = beat_buf[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read request. Besides the idle case, a read is prefetched on the cycle
  // the last word is accepted, so a stream loses only one bubble per beat.
  // If the last word is stalled the prefetch waits, keeping at most one
  // beat outstanding.
  always_comb begin
    fifo_ren = 1'b0;
    if (!rst && !clear && !fifo_empty) begin
      if (state == ST_IDLE) begin
        fifo_ren = 1'b1;
      end else if (state == ST_DRAIN && handshake && at_last) begin
        fifo_ren = 1'b1;
      end
    end
  end

  // Protocol error: the FIFO always answers a read on the next cycle, so a
  // WAIT cycle without fifo_valid is an error, as is fifo_valid anywhere but
  // WAIT. The cycle after a flush is exempt, since a read that was in flight
  // when clear hit may still land then.
  always_comb begin
    err_set = 1'b0;
    if (!clear) begin
      if (state == ST_WAIT) begin
        err_set = !fifo_valid;
      end else begin
        err_set = fifo_valid && !ignore;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    beat_buf_nxt = beat_buf;
    case (state)
      ST_IDLE: begin
        if (fifo_ren) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_valid) begin
          beat_buf_nxt = fifo_dout;
          idx_nxt      = '0;
          state_nxt    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (at_last) begin
            state_nxt = fifo_ren ? ST_WAIT : ST_IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register. clear drops any held or pending beat like rst does, but
  // keeps err and arms the one-cycle ignore window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      beat_buf <= '0;
      ignore   <= 1'b0;
      err      <= 1'b0;
    end else if (clear) begin
      state    <= ST_IDLE;
      idx      <= '0;
      beat_buf <= '0;
      ignore   <= 1'b1;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      beat_buf <= beat_buf_nxt;
      ignore   <= 1'b0;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
